// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU path plus an iterative RV32M multiply/divide
// unit that back-pressures upstream through oBusy while it iterates.
module ex_stage_md #(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 2
) (
   input  logic            iClk,
   input  logic            iRst,
   input  logic            iValid,
   input  logic            iEx_en,
   input  logic            iMd_en,
   input  logic            iImm_en,
   input  logic [2:0]      iFunc3,
   input  logic [6:0]      iFunc7,
   input  logic [XLEN-1:0] iRs1,
   input  logic [XLEN-1:0] iRs2,
   input  logic [XLEN-1:0] iImm,
   input  logic [4:0]      iRs2_addr,
   input  logic [4:0]      iRd_addr,
   input  logic            iFwExS1_en,
   input  logic            iFwExS2_en,
   input  logic            iFwMeS1_en,
   input  logic            iFwMeS2_en,
   input  logic [XLEN-1:0] iFwMe,
   input  logic            iStall,
   input  logic            iFlush,
   output logic            oBusy,
   output logic            oValid,
   output logic [4:0]      oRd_addr,
   output logic [XLEN-1:0] oRd_value,
   output logic [4:0]      oRs_addr,
   output logic [XLEN-1:0] oRs_value
);

   localparam int CW = $clog2(XLEN + 1);
   localparam int SW = $clog2(XLEN);
   localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
   localparam logic [XLEN-1:0]   ZERO    = {XLEN{1'b0}};
   localparam logic [XLEN-1:0]   ONES    = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]   MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [2*XLEN-1:0] ZERO2   = {(2*XLEN){1'b0}};
   localparam logic [CW-1:0]     ONE_C   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]     MUL_STEPS = CW'(XLEN / MUL_BITS);
   localparam logic [CW-1:0]     DIV_STEPS = CW'(XLEN);

   logic [1:0]        state;
   logic [1:0]        md_op;
   logic [4:0]        md_rd, md_rs2_addr;
   logic [XLEN-1:0]   md_s2, md_res, opb;
   logic [2*XLEN-1:0] acc, opa;
   logic [CW-1:0]     cnt;
   logic              neg;

   logic [XLEN-1:0] s1, s2, alu_b, alu_res;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic            alt;
   logic [SW-1:0]   shamt;

   // Operand forwarding (MEM beats EX) and the base-ISA ALU.
   always_comb begin
      if (iFwMeS1_en)      s1 = iFwMe;
      else if (iFwExS1_en) s1 = oRd_value;
      else                 s1 = iRs1;
      if (iFwMeS2_en)      s2 = iFwMe;
      else if (iFwExS2_en) s2 = oRd_value;
      else                 s2 = iRs2;
      alu_b = iImm_en ? iImm : s2;
      f3    = (iEx_en & iValid) ? iFunc3 : 3'd0;
      f7    = (iEx_en & iValid) ? iFunc7 : 7'd0;
      alt   = (f7 == 7'b0100000);
      shamt = alu_b[SW-1:0];
      case (f3)
         3'd0:    alu_res = (alt & ~iImm_en) ? (s1 - alu_b) : (s1 + alu_b);
         3'd1:    alu_res = s1 << shamt;
         3'd2:    alu_res = {{(XLEN-1){1'b0}}, ($signed(s1) < $signed(alu_b))};
         3'd3:    alu_res = {{(XLEN-1){1'b0}}, (s1 < alu_b)};
         3'd4:    alu_res = s1 ^ alu_b;
         3'd5:    alu_res = alt ? $unsigned($signed(s1) >>> shamt) : (s1 >> shamt);
         3'd6:    alu_res = s1 | alu_b;
         3'd7:    alu_res = s1 & alu_b;
         default: alu_res = s1 + alu_b;
      endcase
   end

   logic            start, is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0] a_mag, b_mag, spec_res;

   // Start decode: operand magnitudes, result sign and division special cases.
   always_comb begin
      start    = iValid & iMd_en & (state == S_IDLE);
      is_div   = iFunc3[2];
      sgn_a    = is_div ? ~iFunc3[0] : (iFunc3 != 3'd3);
      sgn_b    = is_div ? ~iFunc3[0] : ~iFunc3[1];
      a_neg    = sgn_a & s1[XLEN-1];
      b_neg    = sgn_b & s2[XLEN-1];
      a_mag    = a_neg ? (ZERO - s1) : s1;
      b_mag    = b_neg ? (ZERO - s2) : s2;
      div_zero = (s2 == ZERO);
      div_ovf  = ~iFunc3[0] & (s1 == MIN_NEG) & (s2 == ONES);
      if (div_zero)     spec_res = iFunc3[1] ? s1 : ONES;
      else if (div_ovf) spec_res = iFunc3[1] ? ZERO : s1;
      else              spec_res = ZERO;
   end

   assign oBusy = start | (state == S_MUL) | (state == S_DIV);

   logic [2*XLEN-1:0] mul_sum, mul_acc, prod, div_acc;
   logic [XLEN:0]     rem_sh, diff;
   logic [XLEN-1:0]   mul_res, div_mag, div_res;

   // One iteration step; div keeps {remainder, quotient/dividend} in acc.
   always_comb begin
      mul_sum = ZERO2;
      for (int i = 0; i < MUL_BITS; i++) begin
         mul_sum = mul_sum + (opb[i] ? (opa << i) : ZERO2);
      end
      mul_acc = acc + mul_sum;
      prod    = neg ? (ZERO2 - mul_acc) : mul_acc;
      mul_res = (md_op == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      rem_sh  = acc[2*XLEN-1:XLEN-1];
      diff    = rem_sh - {1'b0, opa[XLEN-1:0]};
      if (diff[XLEN]) div_acc = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else            div_acc = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      div_mag = md_op[1] ? div_acc[2*XLEN-1:XLEN] : div_acc[XLEN-1:0];
      div_res = neg ? (ZERO - div_mag) : div_mag;
   end

   // State machine, working registers and the EX/MEM output register.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state <= S_IDLE;  md_op <= 2'd0;  md_rd <= 5'd0;  md_rs2_addr <= 5'd0;
         md_s2 <= ZERO;    md_res <= ZERO; opb <= ZERO;    acc <= ZERO2;
         opa <= ZERO2;     cnt <= {CW{1'b0}}; neg <= 1'b0;
         oValid <= 1'b0;   oRd_addr <= 5'd0; oRd_value <= ZERO;
         oRs_addr <= 5'd0; oRs_value <= ZERO;
      end else if (iFlush) begin
         state <= S_IDLE;
         oValid <= 1'b0;   oRd_addr <= 5'd0; oRd_value <= ZERO;
         oRs_addr <= 5'd0; oRs_value <= ZERO;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  md_op       <= iFunc3[1:0];
                  md_rd       <= iRd_addr;
                  md_rs2_addr <= iRs2_addr;
                  md_s2       <= s2;
                  neg         <= (is_div & iFunc3[1]) ? a_neg : (a_neg ^ b_neg);
                  if (is_div & (div_zero | div_ovf)) begin
                     md_res <= spec_res;
                     state  <= S_DONE;
                  end else if (is_div) begin
                     acc   <= {ZERO, a_mag};
                     opa   <= {ZERO, b_mag};
                     opb   <= ZERO;
                     cnt   <= DIV_STEPS;
                     state <= S_DIV;
                  end else begin
                     acc   <= ZERO2;
                     opa   <= {ZERO, a_mag};
                     opb   <= b_mag;
                     cnt   <= MUL_STEPS;
                     state <= S_MUL;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_MUL: begin
               acc <= mul_acc;
               opa <= opa << MUL_BITS;
               opb <= opb >> MUL_BITS;
               cnt <= cnt - ONE_C;
               if (cnt == ONE_C) begin
                  md_res <= mul_res;
                  state  <= S_DONE;
               end else begin
                  state <= S_MUL;
               end
            end
            S_DIV: begin
               acc <= div_acc;
               cnt <= cnt - ONE_C;
               if (cnt == ONE_C) begin
                  md_res <= div_res;
                  state  <= S_DONE;
               end else begin
                  state <= S_DIV;
               end
            end
            S_DONE:  state <= iStall ? S_DONE : S_IDLE;
            default: state <= S_IDLE;
         endcase
         if (!iStall) begin
            if (state == S_DONE) begin
               oValid <= 1'b1;      oRd_addr <= md_rd;      oRd_value <= md_res;
               oRs_addr <= md_rs2_addr; oRs_value <= md_s2;
            end else if (oBusy) begin
               oValid <= 1'b0;      oRd_addr <= 5'd0;       oRd_value <= ZERO;
               oRs_addr <= 5'd0;    oRs_value <= ZERO;
            end else begin
               oValid <= iValid;    oRd_addr <= iRd_addr;   oRd_value <= alu_res;
               oRs_addr <= iRs2_addr; oRs_value <= s2;
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: a scoreboard queue holds every expected
// retirement, and a negedge monitor pops and compares it when one appears.
module tb_ex_stage_md;

   logic        clk = 1'b0;
   logic        iRst, iValid, iEx_en, iMd_en, iImm_en;
   logic [2:0]  iFunc3;
   logic [6:0]  iFunc7;
   logic [31:0] iRs1, iRs2, iImm, iFwMe;
   logic [4:0]  iRs2_addr, iRd_addr;
   logic        iFwExS1_en, iFwExS2_en, iFwMeS1_en, iFwMeS2_en, iStall, iFlush;
   logic        oBusy, oValid;
   logic [4:0]  oRd_addr, oRs_addr;
   logic [31:0] oRd_value, oRs_value;

   typedef logic [73:0] exp_t;
   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;
   logic load_edge = 1'b0;

   always #5 clk = ~clk;

   ex_stage_md #(.XLEN(32), .MUL_BITS(2)) dut (
      .iClk(clk), .iRst(iRst), .iValid(iValid), .iEx_en(iEx_en), .iMd_en(iMd_en),
      .iImm_en(iImm_en), .iFunc3(iFunc3), .iFunc7(iFunc7), .iRs1(iRs1), .iRs2(iRs2),
      .iImm(iImm), .iRs2_addr(iRs2_addr), .iRd_addr(iRd_addr),
      .iFwExS1_en(iFwExS1_en), .iFwExS2_en(iFwExS2_en), .iFwMeS1_en(iFwMeS1_en),
      .iFwMeS2_en(iFwMeS2_en), .iFwMe(iFwMe), .iStall(iStall), .iFlush(iFlush),
      .oBusy(oBusy), .oValid(oValid), .oRd_addr(oRd_addr), .oRd_value(oRd_value),
      .oRs_addr(oRs_addr), .oRs_value(oRs_value)
   );

   // Remember whether the last rising edge was allowed to load the output register.
   always @(posedge clk) load_edge <= !iRst && !iFlush && !iStall;

   // Every valid load must match the oldest expected retirement.
   always @(negedge clk) begin
      exp_t e;
      if (load_edge && oValid === 1'b1) begin
         tests++;
         assert (sb_q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_retire: got rd=%0d val=%h, expected no retirement", oRd_addr, oRd_value);
         end
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            tests++;
            assert ({oRd_addr, oRd_value, oRs_addr, oRs_value} === e) else begin
               fails++;
               $error("FAIL retire: got %h expected %h", {oRd_addr, oRd_value, oRs_addr, oRs_value}, e);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      iValid = 1'b0; iEx_en = 1'b0; iMd_en = 1'b0; iImm_en = 1'b0;
      iFunc3 = 3'd0; iFunc7 = 7'd0;
      iFwExS1_en = 1'b0; iFwExS2_en = 1'b0; iFwMeS1_en = 1'b0; iFwMeS2_en = 1'b0;
   endtask

   task automatic alu(input logic [2:0] f3, input logic [6:0] f7, input logic ex, input logic imm_en,
                      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                      input logic [4:0] rd, input logic [31:0] exp_val, input logic [31:0] exp_rs);
      iValid = 1'b1; iEx_en = ex; iMd_en = 1'b0; iImm_en = imm_en;
      iFunc3 = f3; iFunc7 = f7; iRs1 = rs1; iRs2 = rs2; iImm = imm;
      iRd_addr = rd; iRs2_addr = rd + 5'd8;
      sb_q.push_back({rd, exp_val, 5'(rd + 5'd8), exp_rs});
      step();
      check("alu_latency", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic md_drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
      iValid = 1'b1; iEx_en = 1'b0; iMd_en = 1'b1; iImm_en = 1'b0;
      iFunc3 = f3; iFunc7 = 7'd1; iRs1 = a; iRs2 = b;
      iRd_addr = rd; iRs2_addr = rd + 5'd8;
   endtask

   task automatic drain(input string tag, input int exp_steps);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         step();
         n++;
      end
      check(tag, 32'(n), 32'(exp_steps));
   endtask

   task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_val, input int exp_busy,
                         input string tag);
      int busy;
      busy = 0;
      md_drive(f3, a, b, rd);
      sb_q.push_back({rd, exp_val, 5'(rd + 5'd8), b});
      #1;
      while (oBusy === 1'b1 && busy < 100) begin
         busy++;
         @(negedge clk);
         #2;
      end
      idle();
      check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
      drain({tag, "_retire"}, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]        ra, rb;
      logic [63:0]        up;
      logic signed [63:0] sp;
      int                 busy;

      idle();
      iStall = 1'b0; iFlush = 1'b0; iRst = 1'b1;
      iRs1 = 32'd0; iRs2 = 32'd0; iImm = 32'd0; iFwMe = 32'd0;
      iRd_addr = 5'd0; iRs2_addr = 5'd0;
      repeat (2) step();
      check("rst_valid", {31'd0, oValid}, 32'd0);
      check("rst_rd_addr", {27'd0, oRd_addr}, 32'd0);
      check("rst_rd_value", oRd_value, 32'd0);
      check("rst_rs_addr", {27'd0, oRs_addr}, 32'd0);
      check("rst_rs_value", oRs_value, 32'd0);
      check("rst_busy", {31'd0, oBusy}, 32'd0);
      iRst = 1'b0;

      // ALU path and forwarding
      alu(3'd0, 7'd0, 1'b1, 1'b1, 32'd3, 32'h55, 32'd7, 5'd1, 32'd10, 32'h55);
      iFwExS1_en = 1'b1;
      alu(3'd0, 7'd0, 1'b1, 1'b1, 32'd5, 32'd0, 32'd7, 5'd2, 32'd17, 32'd0);
      iFwMe = 32'd100; iFwMeS1_en = 1'b1; iFwExS1_en = 1'b1; iFwExS2_en = 1'b1;
      alu(3'd0, 7'd0, 1'b1, 1'b1, 32'd5, 32'd9, 32'd7, 5'd3, 32'd107, 32'd17);
      idle();
      alu(3'd0, 7'h20, 1'b1, 1'b0, 32'd20, 32'd30, 32'd0, 5'd4, 32'hFFFF_FFF6, 32'd30);
      alu(3'd2, 7'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd5, 32'd1, 32'd1);
      alu(3'd3, 7'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd6, 32'd0, 32'd1);
      alu(3'd5, 7'h20, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 5'd7, 32'hF800_0000, 32'd0);
      alu(3'd4, 7'h20, 1'b0, 1'b1, 32'h100, 32'd3, 32'h20, 5'd8, 32'h120, 32'd3);
      iFwMeS2_en = 1'b1; iFwMe = 32'hABCD;
      alu(3'd7, 7'd0, 1'b1, 1'b0, 32'hFF0F, 32'h1234, 32'd0, 5'd9, 32'hAB0D, 32'hABCD);
      idle();
      step();
      check("idle_bubble", {31'd0, oValid}, 32'd0);

      // Multiply family
      run_md(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0001, 17, "mul");
      run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 17, "mulhu");
      run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 17, "mulh");
      run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFF, 17, "mulhsu");
      ra = $urandom; rb = $urandom;
      up = {32'd0, ra} * {32'd0, rb};
      sp = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
      run_md(3'd0, ra, rb, 5'd14, up[31:0], 17, "mul_rand");
      run_md(3'd3, ra, rb, 5'd15, up[63:32], 17, "mulhu_rand");
      run_md(3'd1, ra, rb, 5'd16, sp[63:32], 17, "mulh_rand");

      // Divide family and special cases
      run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd17, 32'hFFFF_FFFD, 33, "div");
      run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd18, 32'hFFFF_FFFF, 33, "rem");
      run_md(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd19, 32'hFFFF_FFFD, 33, "div_negb");
      run_md(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd20, 32'd1, 33, "rem_negb");
      rb = $urandom_range(1, 1000);
      run_md(3'd5, ra, rb, 5'd21, ra / rb, 33, "divu_rand");
      run_md(3'd7, ra, rb, 5'd22, ra % rb, 33, "remu_rand");
      run_md(3'd5, 32'd123, 32'd0, 5'd23, 32'hFFFF_FFFF, 1, "divu0");
      run_md(3'd7, 32'd123, 32'd0, 5'd24, 32'd123, 1, "remu0");
      run_md(3'd4, 32'd55, 32'd0, 5'd25, 32'hFFFF_FFFF, 1, "div0");
      run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd26, 32'h8000_0000, 1, "div_ovf");
      run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd27, 32'd0, 1, "rem_ovf");

      // Stall across cycles 10..40 of a DIV
      md_drive(3'd4, 32'd100, 32'd7, 5'd28);
      sb_q.push_back({5'd28, 32'd14, 5'd4, 32'd7});
      busy = 0;
      for (int c = 1; c <= 42; c++) begin
         iStall = (c >= 10 && c <= 40);
         #1;
         if (oBusy === 1'b1) busy++;
         else idle();
         if (c == 41) check("stall_hold", 32'(sb_q.size()), 32'd1);
         step();
      end
      check("stall_retire", 32'(sb_q.size()), 32'd0);
      check("stall_busy", 32'(busy), 32'd33);

      // Flush in cycle 5 of a MUL, overriding a stall that holds a valid result
      alu(3'd0, 7'd0, 1'b1, 1'b1, 32'h40, 32'd0, 32'd2, 5'd29, 32'h42, 32'd0);
      md_drive(3'd0, 32'd9, 32'd9, 5'd30);
      iStall = 1'b1;
      repeat (4) step();
      iFlush = 1'b1;
      idle();
      step();
      iFlush = 1'b0; iStall = 1'b0;
      check("flush_valid", {31'd0, oValid}, 32'd0);
      check("flush_rd_value", oRd_value, 32'd0);
      check("flush_rd_addr", {27'd0, oRd_addr}, 32'd0);
      check("flush_busy", {31'd0, oBusy}, 32'd0);
      repeat (25) step();

      // Flush on the start cycle: nothing starts
      md_drive(3'd4, 32'd100, 32'd3, 5'd31);
      iFlush = 1'b1;
      step();
      iFlush = 1'b0;
      idle();
      #1;
      check("flush_start_busy", {31'd0, oBusy}, 32'd0);
      repeat (40) step();

      // Reset in the middle of a DIV
      alu(3'd0, 7'd0, 1'b1, 1'b0, 32'h1234, 32'h77, 32'd0, 5'd1, 32'h12AB, 32'h77);
      md_drive(3'd5, 32'd1000, 32'd3, 5'd2);
      iStall = 1'b1;
      repeat (10) step();
      check("pre_rst_busy", {31'd0, oBusy}, 32'd1);
      iRst = 1'b1;
      idle();
      step();
      check("mid_rst_valid", {31'd0, oValid}, 32'd0);
      check("mid_rst_rd_addr", {27'd0, oRd_addr}, 32'd0);
      check("mid_rst_rd_value", oRd_value, 32'd0);
      check("mid_rst_rs_addr", {27'd0, oRs_addr}, 32'd0);
      check("mid_rst_rs_value", oRs_value, 32'd0);
      check("mid_rst_busy", {31'd0, oBusy}, 32'd0);
      iRst = 1'b0; iStall = 1'b0;
      alu(3'd6, 7'd0, 1'b1, 1'b1, 32'hF0, 32'd0, 32'h0F, 5'd3, 32'hFF, 32'd0);
      idle();
      repeat (40) step();
      drain("final_drain", 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage with an iterative RV32M multiply/divide unit. It sits between the ID/EX and EX/MEM pipeline registers. Base-ISA ops resolve in one cycle through the existing `ALU`, with the same MEM/EX forwarding priority as the current execute stage. M-extension ops run on a multi-cycle shift-add multiplier and a restoring divider, and the stage back-pressures upstream with `oBusy` while they run.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `MUL_BITS`, 2, multiplier bits retired per cycle; must divide `XLEN` (1, 2, 4 or 8).

Ports:
- `iClk`  in  1  clock, rising edge.
- `iRst`  in  1  reset, synchronous, active-high.
- `iValid`  in  1  ID/EX entry is valid.
- `iEx_en`, `iMd_en`, `iImm_en`  in  1 each  ALU op, M-extension op, use immediate as operand B.
- `iFunc3`  in  3  function 3; `iFunc7`  in  7  function 7.
- `iRs1`, `iRs2`, `iImm`  in  XLEN each  operand values.
- `iRs2_addr`, `iRd_addr`  in  5 each  register addresses.
- `iFwExS1_en`, `iFwExS2_en`  in  1 each  forward `oRd_value` onto S1 / S2.
- `iFwMeS1_en`, `iFwMeS2_en`  in  1 each  forward `iFwMe` onto S1 / S2; these have priority over the EX forwards.
- `iFwMe`  in  XLEN  MEM-stage forward value.
- `iStall`  in  1  downstream stall; holds the output register.
- `iFlush`  in  1  flush; clears the output register and aborts any M op.
- `oBusy`  out  1  M op in flight; upstream must hold the ID/EX entry.
- `oValid`  out  1  EX/MEM entry valid.
- `oRd_addr`  out  5; `oRd_value`  out  XLEN  result.
- `oRs_addr`  out  5; `oRs_value`  out  XLEN  forwarded S2, used as store data.

## Operation
- **Operand select (combinational):** identical for S1 and S2. MEM forward wins, then EX forward, then the register value. ALU B is `iImm` when `iImm_en`, otherwise S2.
- **M-op detect:** `start = iValid & iMd_en & (state==IDLE)`.
- **`iFunc3` decode:** 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- **States:**
  - IDLE: not `start` → single-cycle path. `start` → latch forwarded S1/S2, `iFunc3`, `iRd_addr`, `iRs2_addr` and S2 into working registers.
    - DIV/REM special case → DONE.
    - Multiply → MUL, count = XLEN/MUL_BITS.
    - Divide → DIV, count = XLEN.
  - MUL: one step per cycle, `MUL_BITS` partial products on operand magnitudes; at count==1 → DONE.
  - DIV: one restoring-division bit per cycle on magnitudes; at count==1 → DONE.
  - DONE: result is final. `!iStall` → register the result with `oValid=1`, → IDLE. `iStall` → stay in DONE.
- **Sign fix:** applied after the last step.
  - MULH: signed×signed.
  - MULHSU: signed S1 × unsigned S2.
  - DIV/REM: quotient sign = sign(A)^sign(B); remainder takes the sign of the dividend.
- **Division special cases (no iteration):**
  - Divide by zero: quotient = all-ones, remainder = dividend.
  - DIV/REM of −2^(XLEN−1) by −1: quotient = dividend, remainder = 0.
- **`oBusy`** = (state==IDLE & start) | state==MUL | state==DIV. It is 0 in DONE, so upstream advances on the edge that retires the result. DONE never restarts.
- **Output register:** on every edge with `!iStall` and no `iFlush`:
  - ALU path: `oValid`=`iValid`, `oRd_value`=ALU result. Func fields are forced to 0 when `!(iEx_en & iValid)`.
  - While state is IDLE-with-start, MUL or DIV: a bubble is loaded (`oValid=0`); address and value fields are don't-care but deterministic.

## Timing
- **Reset** (`iRst` high at an edge): state = IDLE; `oValid`, `oRd_addr`, `oRd_value`, `oRs_addr`, `oRs_value` = 0; working registers = 0; `oBusy` = 0 afterwards.
- **ALU op latency:** 1 cycle, from the ID/EX entry to the output register.
- **MUL-family:**
  - `oBusy` high for 1 + XLEN/MUL_BITS cycles: 17 at defaults.
  - The result appears in the output register on the edge ending DONE.
  - Occupancy is XLEN/MUL_BITS + 2 cycles.
- **DIV-family:** `oBusy` high for 1 + XLEN cycles (33). Special cases: `oBusy` high for 1 cycle only.
- **Forwarding** is sampled only in the IDLE/start cycle; later changes on the forward inputs are ignored.
- **`iStall` during MUL/DIV:** iteration continues. The result waits in DONE for `!iStall`.
- **`iFlush`:** takes priority over `iStall` and completion. Output register cleared; state → IDLE next cycle; no result retires. `iRst` behaves the same way at any point.
- **`iFlush` and `start` on the same cycle:** the flush wins and no M op starts.

## Test plan
- **ALU ADD with EX forward:** `iRs1`=5, `iImm`=7, `iImm_en`=1, `iFwExS1_en` with prior `oRd_value`=10 → next cycle `oRd_value`=17, `oValid`=1.
- **MUL and MULHU** 0xFFFFFFFF×0xFFFFFFFF:
  - `oBusy` is high for exactly 17 cycles.
  - MUL retires with `oRd_value`=0x00000001; MULHU gives 0xFFFFFFFE.
  - Every output-register load during `oBusy` is a bubble.
- **Signed division:** DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1). Each has `oBusy` high for 33 cycles.
- **Division special cases:**
  - DIVU 123/0 → 0xFFFFFFFF; REMU 123/0 → 123.
  - DIV 0x80000000/−1 → 0x80000000.
  - Each has `oBusy` high for 1 cycle.
- **Stall and flush:**
  - `iStall` held across cycles 10–40 of a DIV → result retires on the first edge after `iStall` drops.
  - `iFlush` in cycle 5 of a MUL → `oValid`=0, state IDLE, no retirement.
- **Reset mid-op:** `iRst` during DIV iteration → all outputs 0 next cycle. A following ALU op completes in 1 cycle.
